// File: rtl/sram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_pkg
//   Shared types and constants for the SRAM port arbiter slice.
//   - state_t      : arbiter FSM state encoding
//   - port_t       : requester identifier (data / fetch)
//   - widths       : CPU word, SRAM halfword, SRAM halfword address
//   - sram_word_idx: extracts the SRAM word index from an effective address
// ---------------------------------------------------------------------------
package sram_port_arbiter_pkg;

    localparam int WORD_W  = 32;
    localparam int HALF_W  = 16;
    localparam int SRAM_AW = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic port_t;
    localparam port_t PORT_DATA  = 1'b0;
    localparam port_t PORT_FETCH = 1'b1;

    // A 32-bit word occupies two consecutive halfwords, so the word index is
    // the halfword address without its lowest bit. Bits above 18 alias.
    function automatic logic [SRAM_AW-2:0] sram_word_idx(input logic [WORD_W-1:0] ea);
        return ea[SRAM_AW:2];
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// ---------------------------------------------------------------------------
// sram_phase_counter
//   Small up/down counter used to time each SRAM phase.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - synchronous active-low clear (count -> 0)
//     load       - load load_value (has priority over counting)
//     load_value - value loaded when load is high
//     en         - count enable
//     up         - 1: count up, 0: count down
//     terminal   - value at which tc is asserted
//     count      - current count
//     tc         - terminal-count flag (count == terminal), combinational
// ---------------------------------------------------------------------------
module sram_phase_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one 16-bit SRAM between the MEM-stage data port (read/write) and
//   the instruction-fetch port (read-only). Each 32-bit access is two SRAM
//   phases (low halfword, then high halfword) of ACC_CYCLES cycles each,
//   followed by a one-cycle DONE state that pulses the granted port's ack.
//   Contention alternates grants, starting with the data port after reset.
//   Ports:
//     clk, rst               - clock; synchronous active-low reset
//     d_rd_en/d_wr_en        - data read / write request (both = write)
//     d_addr, d_wdata        - data byte address (offset by D_BASE), write word
//     d_rdata, d_ack         - data read word, completion pulse
//     i_rd_en, i_addr        - fetch read request, byte address (no offset)
//     i_rdata, i_ack         - fetch read word, completion pulse
//     busy                   - high whenever the FSM is not IDLE
//     SRAM_ADDR/DQ/WE_N      - SRAM halfword address, data bus, write enable
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 2,
    parameter logic [31:0] D_BASE     = 32'd1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_rd_en,
    input  logic                 d_wr_en,
    input  logic [WORD_W-1:0]    d_addr,
    input  logic [WORD_W-1:0]    d_wdata,
    output logic [WORD_W-1:0]    d_rdata,
    output logic                 d_ack,
    input  logic                 i_rd_en,
    input  logic [WORD_W-1:0]    i_addr,
    output logic [WORD_W-1:0]    i_rdata,
    output logic                 i_ack,
    output logic                 busy,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    inout  wire  [HALF_W-1:0]    SRAM_DQ,
    output logic                 SRAM_WE_N
);

    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(ACC_CYCLES - 1);

    state_t               state;
    port_t                grant;
    port_t                last_grant;
    logic                 is_write;
    logic [SRAM_AW-2:0]   word_idx;
    logic [WORD_W-1:0]    wdata_q;
    logic                 dq_oe;
    logic [HALF_W-1:0]    dq_out;

    // Grant decision for the current IDLE cycle.
    logic                 d_req;
    port_t                next_grant;
    logic                 next_write;
    logic [WORD_W-1:0]    next_ea;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        d_req      = d_rd_en | d_wr_en;
        next_grant = PORT_FETCH;
        if (d_req && i_rd_en) begin
            next_grant = ~last_grant;
        end else if (d_req) begin
            next_grant = PORT_DATA;
        end
        // A simultaneous read and write request is served as a write.
        next_write = (next_grant == PORT_DATA) && d_wr_en;
        next_ea    = (next_grant == PORT_DATA) ? (d_addr - D_BASE) : i_addr;
    end

    // Phase timer: held at zero outside LOW/HIGH and reloaded at the end of
    // each phase, so every phase starts counting from zero.
    logic             in_phase;
    logic             phase_tc;
    logic [CNT_W-1:0] phase_count;

    assign in_phase = (state == LOW) || (state == HIGH);

    sram_phase_counter #(
        .WIDTH(CNT_W)
    ) u_phase_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (!in_phase || phase_tc),
        .load_value('0),
        .en        (in_phase),
        .up        (1'b1),
        .terminal  (PHASE_LAST),
        .count     (phase_count),
        .tc        (phase_tc)
    );

    // Effective-address bits outside the SRAM window are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{next_ea[WORD_W-1:SRAM_AW+1], next_ea[1:0], phase_count};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= PORT_FETCH;
            last_grant <= PORT_FETCH;
            is_write   <= 1'b0;
            word_idx   <= '0;
            wdata_q    <= '0;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
            d_ack      <= 1'b0;
            i_ack      <= 1'b0;
            busy       <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            d_rdata    <= '0;
            i_rdata    <= '0;
        end else begin
            d_ack <= 1'b0;
            i_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_req || i_rd_en) begin
                        state      <= LOW;
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        is_write   <= next_write;
                        word_idx   <= sram_word_idx(next_ea);
                        wdata_q    <= d_wdata;
                        busy       <= 1'b1;
                        SRAM_ADDR  <= {sram_word_idx(next_ea), 1'b0};
                        SRAM_WE_N  <= ~next_write;
                        dq_oe      <= next_write;
                        dq_out     <= d_wdata[HALF_W-1:0];
                    end
                end
                LOW: begin
                    if (phase_tc) begin
                        if (!is_write) begin
                            if (grant == PORT_DATA) d_rdata[HALF_W-1:0] <= SRAM_DQ;
                            else                    i_rdata[HALF_W-1:0] <= SRAM_DQ;
                        end
                        state     <= HIGH;
                        SRAM_ADDR <= {word_idx, 1'b1};
                        dq_out    <= wdata_q[WORD_W-1:HALF_W];
                    end
                end
                HIGH: begin
                    if (phase_tc) begin
                        if (!is_write) begin
                            if (grant == PORT_DATA) d_rdata[WORD_W-1:HALF_W] <= SRAM_DQ;
                            else                    i_rdata[WORD_W-1:HALF_W] <= SRAM_DQ;
                        end
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (grant == PORT_DATA) d_ack <= 1'b1;
                        else                    i_ack <= 1'b1;
                    end
                end
                DONE: begin
                    // Always return to IDLE so back-to-back requests see a
                    // fresh arbitration cycle.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : {HALF_W{1'bz}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Bench for sram_port_arbiter with a behavioural SRAM, directed scenario
//   tasks and a randomized scoreboard run (word-level memory image, grant
//   order derived from the alternation rule, fixed access latencies).
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ACC   = 2;
    localparam int LAT1  = 2 * ACC + 1;       // first access: ack cycle after grant
    localparam int LAT2  = 2 * LAT1 + 1;      // queued second access
    localparam int SPACE = 2 * ACC + 2;       // ack-to-ack spacing under contention

    logic        clk;
    logic        rst;
    logic        d_rd_en, d_wr_en, i_rd_en;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic [31:0] d_rdata, i_rdata;
    logic        d_ack, i_ack, busy;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural SRAM: writes on any edge with WE_N low, drives the bus on
    // reads while the arbiter is busy. probe_en forces a known pattern so the
    // bench can tell whether the DUT has released the bus.
    logic [15:0] sram_mem [0:(1<<18)-1];
    logic        probe_en;

    always @(posedge clk) begin
        if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;
    end

    assign SRAM_DQ = probe_en ? 16'h5A5A :
                     ((busy && SRAM_WE_N) ? sram_mem[SRAM_ADDR] : 16'hzzzz);

    // Reference state for the randomized run.
    logic [31:0] gold [16];
    logic [31:0] exp_d_rdata;
    logic        tb_last;    // 0 = data, 1 = fetch

    sram_port_arbiter #(
        .ACC_CYCLES(ACC),
        .D_BASE    (32'd1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_rd_en  (d_rd_en),
        .d_wr_en  (d_wr_en),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .i_rd_en  (i_rd_en),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .busy     (busy),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ  (SRAM_DQ),
        .SRAM_WE_N(SRAM_WE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues the given requests from IDLE, drops each at its ack and records
    // ack cycle (counted from the granting edge), read data, the SRAM address
    // in the first LOW/HIGH cycle and whether WE_N stayed low in both phases.
    task automatic run_txn(input logic drd, input logic dwr, input logic [31:0] da,
                           input logic [31:0] dw, input logic irq, input logic [31:0] ia,
                           output logic [31:0] d_got, output logic [31:0] i_got,
                           output int d_at, output int i_at,
                           output logic [17:0] a_lo, output logic [17:0] a_hi,
                           output logic we_low, output logic stray);
        int   n;
        logic d_pend, i_pend;
        @(negedge clk);
        d_rd_en = drd; d_wr_en = dwr; d_addr = da; d_wdata = dw;
        i_rd_en = irq; i_addr = ia;
        d_pend = drd | dwr; i_pend = irq;
        d_at = -1; i_at = -1; d_got = '0; i_got = '0;
        a_lo = '0; a_hi = '0; we_low = 1'b1; stray = 1'b0; n = 0;
        while ((d_pend || i_pend) && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1)       a_lo = SRAM_ADDR;
            if (n == ACC + 1) a_hi = SRAM_ADDR;
            if (n <= 2 * ACC && SRAM_WE_N) we_low = 1'b0;
            if ((d_ack && !d_pend) || (i_ack && !i_pend) || (d_ack && i_ack)) stray = 1'b1;
            if (d_ack && d_pend) begin
                d_at = n; d_got = d_rdata; d_pend = 1'b0;
                d_rd_en = 1'b0; d_wr_en = 1'b0;
            end
            if (i_ack && i_pend) begin
                i_at = n; i_got = i_rdata; i_pend = 1'b0;
                i_rd_en = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; probe_en = 1'b0;
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        d_addr = '0; d_wdata = '0; i_addr = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({d_ack, i_ack, busy, SRAM_WE_N} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: {d_ack,i_ack,busy,we_n}=%b expected 0001", {d_ack, i_ack, busy, SRAM_WE_N});
        end
        vectors++;
        if (SRAM_ADDR !== 18'h0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: addr=%h d_rdata=%h i_rdata=%h expected zeros", SRAM_ADDR, d_rdata, i_rdata);
        end
        probe_en = 1'b1;
        #1;
        vectors++;
        if (SRAM_DQ !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL reset_dq_released: bus=%h expected %h", SRAM_DQ, 16'h5A5A);
        end
        probe_en = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] dg, ig; int da_t, ia_t; logic [17:0] lo, hi; logic wl, st;
        run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (da_t !== LAT1) begin
            miscompares++;
            $display("FAIL write_latency: ack at %0d expected %0d", da_t, LAT1);
        end
        vectors++;
        if (sram_mem[2] !== 16'hBEEF || sram_mem[3] !== 16'hDEAD) begin
            miscompares++;
            $display("FAIL write_mem: hw2=%h hw3=%h expected beef dead", sram_mem[2], sram_mem[3]);
        end
        vectors++;
        if (lo !== 18'd2 || hi !== 18'd3 || wl !== 1'b1) begin
            miscompares++;
            $display("FAIL write_bus: lo=%h hi=%h we_low=%b expected 2 3 1", lo, hi, wl);
        end
        run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (dg !== 32'hDEADBEEF || da_t !== LAT1) begin
            miscompares++;
            $display("FAIL read_back: d_rdata=%h at %0d expected deadbeef at %0d", dg, da_t, LAT1);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] dg, ig; int da_t, ia_t; logic [17:0] lo, hi; logic wl, st;
        // Data address 1024 maps to the same halfwords as fetch address 0.
        run_txn(1'b0, 1'b1, 32'd1024, 32'hE3A00001, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (ig !== 32'hE3A00001 || ia_t !== LAT1) begin
            miscompares++;
            $display("FAIL fetch_read: i_rdata=%h at %0d expected e3a00001 at %0d", ig, ia_t, LAT1);
        end
        vectors++;
        if (st !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_no_d_ack: stray ack seen=%b expected 0", st);
        end
        @(negedge clk);
        vectors++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_ack_pulse: i_ack=%b d_ack=%b after DONE expected 0 0", i_ack, d_ack);
        end
    endtask

    task automatic test_contention();
        int n, k; logic both;
        logic        port_q [4];
        int          at_q   [4];
        logic [31:0] dat_q  [4];
        apply_reset();
        @(negedge clk);
        d_rd_en = 1'b1; d_wr_en = 1'b0; d_addr = 32'd1028;
        i_rd_en = 1'b1; i_addr = 32'h0;
        n = 0; k = 0; both = 1'b0;
        while (k < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (d_ack && i_ack) both = 1'b1;
            if (d_ack || i_ack) begin
                port_q[k] = i_ack;
                at_q[k]   = n;
                dat_q[k]  = i_ack ? i_rdata : d_rdata;
                k++;
            end
        end
        d_rd_en = 1'b0; i_rd_en = 1'b0;
        vectors++;
        if (k !== 4 || both !== 1'b0) begin
            miscompares++;
            $display("FAIL contention_count: acks=%0d dual=%b expected 4 0", k, both);
        end
        for (int j = 0; j < k; j++) begin
            vectors++;
            if (port_q[j] !== j[0] || at_q[j] !== LAT1 + j * SPACE) begin
                miscompares++;
                $display("FAIL contention_order[%0d]: port=%b at %0d expected port=%b at %0d",
                         j, port_q[j], at_q[j], j[0], LAT1 + j * SPACE);
            end
            vectors++;
            if (dat_q[j] !== (j[0] ? 32'hE3A00001 : 32'hDEADBEEF)) begin
                miscompares++;
                $display("FAIL contention_data[%0d]: got %h expected %h", j, dat_q[j],
                         j[0] ? 32'hE3A00001 : 32'hDEADBEEF);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] dg, ig; int da_t, ia_t; logic [17:0] lo, hi; logic wl, st;
        run_txn(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (lo !== 18'h3FFFE || hi !== 18'h3FFFF || da_t !== LAT1) begin
            miscompares++;
            $display("FAIL addr_wrap: lo=%h hi=%h at %0d expected 3fffe 3ffff at %0d", lo, hi, da_t, LAT1);
        end
        run_txn(1'b0, 1'b1, 32'd1024 + (32'd1 << 19), 32'h12345678, 1'b0, 32'h0,
                dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (lo !== 18'h0 || hi !== 18'h1) begin
            miscompares++;
            $display("FAIL addr_alias: lo=%h hi=%h expected 0 1", lo, hi);
        end
        run_txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (dg !== 32'h12345678) begin
            miscompares++;
            $display("FAIL addr_alias_read: got %h expected 12345678", dg);
        end
    endtask

    task automatic test_rw_both();
        logic [31:0] dg, ig; int da_t, ia_t; logic [17:0] lo, hi; logic wl, st;
        run_txn(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        vectors++;
        if (wl !== 1'b1 || da_t !== LAT1) begin
            miscompares++;
            $display("FAIL rw_both_write: we_low=%b at %0d expected 1 at %0d", wl, da_t, LAT1);
        end
        vectors++;
        if (sram_mem[4] !== 16'hF00D || sram_mem[5] !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL rw_both_mem: hw4=%h hw5=%h expected f00d cafe", sram_mem[4], sram_mem[5]);
        end
        vectors++;
        if (dg !== 32'h12345678) begin
            miscompares++;
            $display("FAIL write_keeps_rdata: d_rdata=%h expected 12345678", dg);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] dg, ig; int da_t, ia_t; logic [17:0] lo, hi; logic wl, st;
        logic seen_ack;
        run_txn(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
        @(negedge clk);
        d_wr_en = 1'b1; d_addr = 32'd1028; d_wdata = 32'hDEADBEEF;
        repeat (ACC + 1) @(negedge clk);
        vectors++;
        if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== 18'd3) begin
            miscompares++;
            $display("FAIL midwrite_high: we_n=%b addr=%h expected 0 3", SRAM_WE_N, SRAM_ADDR);
        end
        rst = 1'b0; d_wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, SRAM_WE_N, d_ack} !== 3'b010 || SRAM_ADDR !== 18'h0 || d_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midwrite_reset: busy=%b we_n=%b d_ack=%b addr=%h d_rdata=%h expected 0 1 0 0 0",
                     busy, SRAM_WE_N, d_ack, SRAM_ADDR, d_rdata);
        end
        vectors++;
        if (sram_mem[2] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL midwrite_low_half: hw2=%h expected beef", sram_mem[2]);
        end
        probe_en = 1'b1;
        #1;
        vectors++;
        if (SRAM_DQ !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL midwrite_dq_released: bus=%h expected %h", SRAM_DQ, 16'h5A5A);
        end
        probe_en = 1'b0;
        rst = 1'b1;
        seen_ack = 1'b0;
        repeat (2 * ACC + 3) begin
            @(negedge clk);
            if (d_ack || i_ack || busy) seen_ack = 1'b1;
        end
        vectors++;
        if (seen_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL midwrite_aborted: activity after reset=%b expected 0", seen_ack);
        end
    endtask

    task automatic test_random();
        logic [31:0] dg, ig, da, dw, ia, exp_i; int da_t, ia_t, exp_dat, exp_iat;
        logic [17:0] lo, hi; logic wl, st;
        logic drd, dwr, irq, d_first;
        int mode, wd, wi;
        // Fill the 16-word window so every later read has a known value.
        exp_d_rdata = 32'h0;
        for (int w = 0; w < 16; w++) begin
            dw = $urandom;
            run_txn(1'b0, 1'b1, 32'd1024 + 32'(w * 4), dw, 1'b0, 32'h0, dg, ig, da_t, ia_t, lo, hi, wl, st);
            gold[w] = dw;
            vectors++;
            if (da_t !== LAT1 || dg !== exp_d_rdata) begin
                miscompares++;
                $display("FAIL rand_fill[%0d]: at %0d rdata=%h expected at %0d rdata=%h", w, da_t, dg, LAT1, exp_d_rdata);
            end
        end
        tb_last = 1'b0;
        for (int it = 0; it < 60; it++) begin
            mode = $urandom_range(0, 4);
            wd = $urandom_range(0, 15);
            wi = $urandom_range(0, 15);
            dw = $urandom;
            da = 32'd1024 + ($urandom << 19) + 32'(wd * 4) + 32'($urandom_range(0, 3));
            ia = ($urandom << 19) + 32'(wi * 4) + 32'($urandom_range(0, 3));
            drd = (mode == 0) || (mode == 3) || ((mode == 1 || mode == 4) && $urandom_range(0, 1) == 1);
            dwr = (mode == 1) || (mode == 4);
            irq = (mode >= 2);
            if ((drd || dwr) && irq) begin
                d_first = (tb_last == 1'b1);
                tb_last = d_first ? 1'b1 : 1'b0;
            end else begin
                d_first = (drd || dwr);
                tb_last = d_first ? 1'b0 : 1'b1;
            end
            exp_i = 32'h0;
            if (irq && !d_first) exp_i = gold[wi];
            if (drd || dwr) begin
                if (dwr) gold[wd] = dw;
                else     exp_d_rdata = gold[wd];
            end
            if (irq && d_first) exp_i = gold[wi];
            exp_dat = !(drd || dwr) ? -1 : (d_first ? LAT1 : LAT2);
            exp_iat = !irq ? -1 : (d_first ? LAT2 : LAT1);
            run_txn(drd, dwr, da, dw, irq, ia, dg, ig, da_t, ia_t, lo, hi, wl, st);
            vectors++;
            if (da_t !== exp_dat || ia_t !== exp_iat || st !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_timing[%0d]: d_at=%0d i_at=%0d stray=%b expected %0d %0d 0",
                         it, da_t, ia_t, st, exp_dat, exp_iat);
            end
            if (drd || dwr) begin
                vectors++;
                if (dg !== exp_d_rdata) begin
                    miscompares++;
                    $display("FAIL rand_d_rdata[%0d]: got %h expected %h", it, dg, exp_d_rdata);
                end
            end
            if (irq) begin
                vectors++;
                if (ig !== exp_i) begin
                    miscompares++;
                    $display("FAIL rand_i_rdata[%0d]: got %h expected %h", it, ig, exp_i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_fetch();
        test_contention();
        test_addr_wrap();
        test_rw_both();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
